// File: rtl/mem_issue_queue_pkg.sv
// Shared types for the memory issue queue: dispatch payload, stored slot and issue bus.
// Register, ROB and store-number widths match the rest of the core.
package mem_issue_queue_pkg;

    localparam int REG_ADDR_W  = 6;
    localparam int ROB_IDX_W   = 4;
    localparam int STORE_NUM_W = 4;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LH  = 4'd1,
        OP_LW  = 4'd2,
        OP_LBU = 4'd3,
        OP_LHU = 4'd4,
        OP_SB  = 4'd5,
        OP_SH  = 4'd6,
        OP_SW  = 4'd7
    } operation_t;

    typedef struct packed {
        operation_t             operation;
        logic [31:0]            imm;
        reg_addr_t              phy_src1;
        reg_addr_t              phy_src2;
        logic                   src1_ready;
        logic                   src2_ready;
        reg_addr_t              phy_dest;
        logic [ROB_IDX_W-1:0]   rob_entry_num;
        logic [STORE_NUM_W-1:0] store_num;
        logic                   pre_store;
    } mem_iq_entry_t;

    // Stored form of an entry; readiness lives in separate per-entry bits.
    typedef struct packed {
        operation_t             operation;
        logic [31:0]            imm;
        reg_addr_t              phy_src1;
        reg_addr_t              phy_src2;
        reg_addr_t              phy_dest;
        logic [ROB_IDX_W-1:0]   rob_entry_num;
        logic [STORE_NUM_W-1:0] store_num;
        logic                   pre_store;
    } iq_slot_t;

    typedef struct packed {
        operation_t             operation;
        logic [31:0]            imm;
        logic [31:0]            src1_value;
        logic [31:0]            src2_value;
        reg_addr_t              phy_dest;
        logic [ROB_IDX_W-1:0]   rob_entry_num;
        logic [STORE_NUM_W-1:0] store_num;
        logic                   pre_store;
    } issue_to_execute_bus_t;

    function automatic iq_slot_t to_slot(input mem_iq_entry_t e);
        iq_slot_t s;
        s.operation     = e.operation;
        s.imm           = e.imm;
        s.phy_src1      = e.phy_src1;
        s.phy_src2      = e.phy_src2;
        s.phy_dest      = e.phy_dest;
        s.rob_entry_num = e.rob_entry_num;
        s.store_num     = e.store_num;
        s.pre_store     = e.pre_store;
        return s;
    endfunction

endpackage

// File: rtl/mem_issue_queue_wakeup_match.sv
// Compares one source tag against every writeback wakeup port and reports a hit.
module mem_issue_queue_wakeup_match
    import mem_issue_queue_pkg::*;
#(
    parameter int WAKEUP_PORTS = 3
) (
    input  reg_addr_t                             tag,
    input  logic [WAKEUP_PORTS-1:0]               wakeup_valid,
    input  logic [WAKEUP_PORTS-1:0][REG_ADDR_W-1:0] wakeup_phy_dest,
    output logic                                  hit
);

    always_comb begin
        hit = 1'b0;
        for (int p = 0; p < WAKEUP_PORTS; p++) begin
            if (wakeup_valid[p] && (wakeup_phy_dest[p] == tag)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue: tracks source readiness via wakeups and
// offers the head op, with PRF operands attached, to the AGU.
module mem_issue_queue
    import mem_issue_queue_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int WAKEUP_PORTS = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  flush,
    input  logic                                  dispatch_valid,
    output logic                                  dispatch_ready,
    input  mem_iq_entry_t                         dispatch_entry,
    input  logic [WAKEUP_PORTS-1:0]               wakeup_valid,
    input  logic [WAKEUP_PORTS-1:0][REG_ADDR_W-1:0] wakeup_phy_dest,
    output reg_addr_t                             rf_raddr1,
    output reg_addr_t                             rf_raddr2,
    input  logic [31:0]                           rf_rdata1,
    input  logic [31:0]                           rf_rdata2,
    output logic                                  issue_to_agu_valid,
    input  logic                                  agu_allowin,
    output issue_to_execute_bus_t                 issue_inst,
    output logic [$clog2(DEPTH):0]                iq_count
);

    localparam int PTR_W = $clog2(DEPTH);

    iq_slot_t         slots [DEPTH];
    logic [DEPTH-1:0] s1_rdy;
    logic [DEPTH-1:0] s2_rdy;
    logic [DEPTH-1:0] hit1;
    logic [DEPTH-1:0] hit2;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             disp_hit1;
    logic             disp_hit2;
    logic             disp_s1_rdy;
    logic             disp_s2_rdy;
    logic             do_dispatch;
    logic             do_pop;
    iq_slot_t         head_slot;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        mem_issue_queue_wakeup_match #(.WAKEUP_PORTS(WAKEUP_PORTS)) u_match1 (
            .tag             (slots[i].phy_src1),
            .wakeup_valid    (wakeup_valid),
            .wakeup_phy_dest (wakeup_phy_dest),
            .hit             (hit1[i])
        );
        mem_issue_queue_wakeup_match #(.WAKEUP_PORTS(WAKEUP_PORTS)) u_match2 (
            .tag             (slots[i].phy_src2),
            .wakeup_valid    (wakeup_valid),
            .wakeup_phy_dest (wakeup_phy_dest),
            .hit             (hit2[i])
        );
    end

    mem_issue_queue_wakeup_match #(.WAKEUP_PORTS(WAKEUP_PORTS)) u_disp_match1 (
        .tag             (dispatch_entry.phy_src1),
        .wakeup_valid    (wakeup_valid),
        .wakeup_phy_dest (wakeup_phy_dest),
        .hit             (disp_hit1)
    );
    mem_issue_queue_wakeup_match #(.WAKEUP_PORTS(WAKEUP_PORTS)) u_disp_match2 (
        .tag             (dispatch_entry.phy_src2),
        .wakeup_valid    (wakeup_valid),
        .wakeup_phy_dest (wakeup_phy_dest),
        .hit             (disp_hit2)
    );

    // Physical register 0 is hardwired, so it never waits on a wakeup.
    assign disp_s1_rdy = dispatch_entry.src1_ready || disp_hit1 || (dispatch_entry.phy_src1 == '0);
    assign disp_s2_rdy = dispatch_entry.src2_ready || disp_hit2 || (dispatch_entry.phy_src2 == '0);

    assign head_slot          = slots[head];
    assign dispatch_ready     = (count != (PTR_W+1)'(DEPTH));
    assign issue_to_agu_valid = (count != '0) && s1_rdy[head] && s2_rdy[head];
    assign do_dispatch        = dispatch_valid && dispatch_ready;
    assign do_pop             = issue_to_agu_valid && agu_allowin;
    assign iq_count           = count;
    assign rf_raddr1          = head_slot.phy_src1;
    assign rf_raddr2          = head_slot.phy_src2;

    always_comb begin
        issue_inst.operation     = head_slot.operation;
        issue_inst.imm           = head_slot.imm;
        issue_inst.src1_value    = rf_rdata1;
        issue_inst.src2_value    = rf_rdata2;
        issue_inst.phy_dest      = head_slot.phy_dest;
        issue_inst.rob_entry_num = head_slot.rob_entry_num;
        issue_inst.store_num     = head_slot.store_num;
        issue_inst.pre_store     = head_slot.pre_store;
    end

    // Wakeups set ready bits first; a dispatch into the tail slot then overrides them.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            s1_rdy <= '0;
            s2_rdy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hit1[i]) s1_rdy[i] <= 1'b1;
                if (hit2[i]) s2_rdy[i] <= 1'b1;
            end
            if (do_dispatch) begin
                slots[tail]  <= to_slot(dispatch_entry);
                s1_rdy[tail] <= disp_s1_rdy;
                s2_rdy[tail] <= disp_s2_rdy;
                tail         <= tail + 1'b1;
            end
            if (do_pop) begin
                head <= head + 1'b1;
            end
            count <= count + (PTR_W+1)'(do_dispatch) - (PTR_W+1)'(do_pop);
        end
    end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Self-checking bench for mem_issue_queue: directed scenarios plus random traffic,
// all compared every cycle against a queue-based reference model.
module tb_mem_issue_queue;
    import mem_issue_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int WP    = 3;

    logic                          clk = 1'b0;
    logic                          reset;
    logic                          flush;
    logic                          dispatch_valid;
    logic                          dispatch_ready;
    mem_iq_entry_t                 dispatch_entry;
    logic [WP-1:0]                 wakeup_valid;
    logic [WP-1:0][REG_ADDR_W-1:0] wakeup_phy_dest;
    reg_addr_t                     rf_raddr1;
    reg_addr_t                     rf_raddr2;
    logic [31:0]                   rf_rdata1;
    logic [31:0]                   rf_rdata2;
    logic                          issue_to_agu_valid;
    logic                          agu_allowin;
    issue_to_execute_bus_t         issue_inst;
    logic [$clog2(DEPTH):0]        iq_count;

    logic [31:0] prf [64];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          rob_ctr  = 0;

    typedef struct {
        mem_iq_entry_t e;
        bit            r1;
        bit            r2;
    } model_slot_t;

    model_slot_t mq[$];

    always #5 clk = ~clk;

    assign rf_rdata1 = prf[rf_raddr1];
    assign rf_rdata2 = prf[rf_raddr2];

    mem_issue_queue #(.DEPTH(DEPTH), .WAKEUP_PORTS(WP)) dut (
        .clk                (clk),
        .reset              (reset),
        .flush              (flush),
        .dispatch_valid     (dispatch_valid),
        .dispatch_ready     (dispatch_ready),
        .dispatch_entry     (dispatch_entry),
        .wakeup_valid       (wakeup_valid),
        .wakeup_phy_dest    (wakeup_phy_dest),
        .rf_raddr1          (rf_raddr1),
        .rf_raddr2          (rf_raddr2),
        .rf_rdata1          (rf_rdata1),
        .rf_rdata2          (rf_rdata2),
        .issue_to_agu_valid (issue_to_agu_valid),
        .agu_allowin        (agu_allowin),
        .issue_inst         (issue_inst),
        .iq_count           (iq_count)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_checks++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        else
            n_pass++;
    endtask

    task automatic applyStimulus(input bit dv, input mem_iq_entry_t e, input logic [WP-1:0] wv,
                                 input logic [WP-1:0][REG_ADDR_W-1:0] wt, input bit allow, input bit fl);
        dispatch_valid  = dv;
        dispatch_entry  = e;
        wakeup_valid    = wv;
        wakeup_phy_dest = wt;
        agu_allowin     = allow;
        flush           = fl;
    endtask

    task automatic idle(input bit allow);
        applyStimulus(1'b0, '0, '0, '0, allow, 1'b0);
    endtask

    function automatic mem_iq_entry_t mkEntry(input operation_t op, input int s1, input int s2,
                                              input bit r1, input bit r2, input int rob);
        mem_iq_entry_t e;
        e.operation     = op;
        e.imm           = $urandom;
        e.phy_src1      = REG_ADDR_W'(s1);
        e.phy_src2      = REG_ADDR_W'(s2);
        e.src1_ready    = r1;
        e.src2_ready    = r2;
        e.phy_dest      = REG_ADDR_W'($urandom_range(1, 63));
        e.rob_entry_num = ROB_IDX_W'(rob);
        e.store_num     = STORE_NUM_W'($urandom);
        e.pre_store     = 1'($urandom);
        return e;
    endfunction

    function automatic bit woken(input reg_addr_t t);
        for (int p = 0; p < WP; p++)
            if (wakeup_valid[p] && wakeup_phy_dest[p] == t) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: queue of ops in program order, updated at each clock edge.
    task automatic modelStep();
        bit          pop;
        bit          push;
        model_slot_t s;
        if (reset || flush) begin
            mq.delete();
        end else begin
            pop  = (mq.size() > 0) && mq[0].r1 && mq[0].r2 && agu_allowin;
            push = dispatch_valid && (mq.size() < DEPTH);
            foreach (mq[i]) begin
                if (woken(mq[i].e.phy_src1)) mq[i].r1 = 1'b1;
                if (woken(mq[i].e.phy_src2)) mq[i].r2 = 1'b1;
            end
            if (pop) void'(mq.pop_front());
            if (push) begin
                s.e  = dispatch_entry;
                s.r1 = dispatch_entry.src1_ready || dispatch_entry.phy_src1 == 0 || woken(dispatch_entry.phy_src1);
                s.r2 = dispatch_entry.src2_ready || dispatch_entry.phy_src2 == 0 || woken(dispatch_entry.phy_src2);
                mq.push_back(s);
            end
        end
    endtask

    task automatic checkAll();
        bit                    exp_valid;
        issue_to_execute_bus_t exp;
        exp_valid = (mq.size() > 0) && mq[0].r1 && mq[0].r2;
        checkOutput("iq_count", 128'(iq_count), 128'(mq.size()));
        checkOutput("dispatch_ready", 128'(dispatch_ready), 128'(mq.size() < DEPTH));
        checkOutput("issue_valid", 128'(issue_to_agu_valid), 128'(exp_valid));
        if (exp_valid) begin
            exp.operation     = mq[0].e.operation;
            exp.imm           = mq[0].e.imm;
            exp.src1_value    = prf[mq[0].e.phy_src1];
            exp.src2_value    = prf[mq[0].e.phy_src2];
            exp.phy_dest      = mq[0].e.phy_dest;
            exp.rob_entry_num = mq[0].e.rob_entry_num;
            exp.store_num     = mq[0].e.store_num;
            exp.pre_store     = mq[0].e.pre_store;
            checkOutput("issue_inst", 128'(issue_inst), 128'(exp));
            checkOutput("rf_raddr1", 128'(rf_raddr1), 128'(mq[0].e.phy_src1));
            checkOutput("rf_raddr2", 128'(rf_raddr2), 128'(mq[0].e.phy_src2));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic dispatchOne(input mem_iq_entry_t e, input bit allow);
        applyStimulus(1'b1, e, '0, '0, allow, 1'b0);
        tick();
        rob_ctr++;
    endtask

    initial begin
        logic [WP-1:0][REG_ADDR_W-1:0] wt;
        logic [WP-1:0]                 wv;

        for (int i = 0; i < 64; i++) prf[i] = $urandom;
        prf[0] = 32'h0;
        prf[5] = 32'h0000_1000;
        reset  = 1'b1;
        idle(1'b0);
        @(posedge clk);
        #1;
        tick();
        tick();
        reset = 1'b0;

        // Basic issue of a fully ready LW
        dispatchOne(mkEntry(OP_LW, 5, 0, 1'b1, 1'b1, rob_ctr), 1'b1);
        checkOutput("basic_valid", 128'(issue_to_agu_valid), 128'(1));
        checkOutput("basic_src1", 128'(issue_inst.src1_value), 128'h1000);
        idle(1'b1);
        tick();
        checkOutput("basic_drain", 128'(iq_count), 128'(0));

        // Late wakeup on src2 through port 1
        dispatchOne(mkEntry(OP_SW, 0, 9, 1'b1, 1'b0, rob_ctr), 1'b1);
        idle(1'b1);
        tick();
        tick();
        checkOutput("wake_pre", 128'(issue_to_agu_valid), 128'(0));
        wt = '0;
        wt[1] = 6'd9;
        applyStimulus(1'b0, '0, 3'b010, wt, 1'b1, 1'b0);
        tick();
        checkOutput("wake_post", 128'(issue_to_agu_valid), 128'(1));
        idle(1'b1);
        tick();

        // Wakeup arriving in the dispatch cycle
        wt = '0;
        wt[0] = 6'd12;
        applyStimulus(1'b1, mkEntry(OP_LH, 12, 0, 1'b0, 1'b1, rob_ctr), 3'b001, wt, 1'b1, 1'b0);
        rob_ctr++;
        tick();
        checkOutput("disp_wake", 128'(issue_to_agu_valid), 128'(1));
        idle(1'b1);
        tick();

        // Fill with a blocked head, then drain in order
        dispatchOne(mkEntry(OP_LW, 20, 0, 1'b0, 1'b1, rob_ctr), 1'b0);
        for (int i = 1; i < DEPTH; i++)
            dispatchOne(mkEntry(OP_LBU, $urandom_range(1, 63), $urandom_range(1, 63), 1'b1, 1'b1, rob_ctr), 1'b1);
        checkOutput("full_ready", 128'(dispatch_ready), 128'(0));
        checkOutput("full_count", 128'(iq_count), 128'(DEPTH));
        dispatchOne(mkEntry(OP_SB, 3, 4, 1'b1, 1'b1, rob_ctr), 1'b1);
        wt = '0;
        wt[2] = 6'd20;
        applyStimulus(1'b0, '0, 3'b100, wt, 1'b1, 1'b0);
        tick();
        idle(1'b1);
        for (int i = 0; i < DEPTH; i++) tick();

        // Backpressure then a long dispatch/issue run that wraps the pointers
        dispatchOne(mkEntry(OP_LW, 7, 8, 1'b1, 1'b1, rob_ctr), 1'b0);
        idle(1'b0);
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 20; i++)
            dispatchOne(mkEntry(OP_SH, $urandom_range(0, 63), $urandom_range(0, 63), 1'b1, 1'b1, rob_ctr), 1'b1);
        idle(1'b1);
        tick();

        // Flush with five entries and a dispatch in the same cycle
        for (int i = 0; i < 5; i++)
            dispatchOne(mkEntry(OP_LB, 2, 3, 1'b1, 1'b1, rob_ctr), 1'b0);
        applyStimulus(1'b1, mkEntry(OP_LW, 1, 1, 1'b1, 1'b1, rob_ctr), '0, '0, 1'b1, 1'b1);
        tick();
        checkOutput("flush_count", 128'(iq_count), 128'(0));
        checkOutput("flush_valid", 128'(issue_to_agu_valid), 128'(0));

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < WP; p++) begin
                wv[p] = ($urandom_range(0, 3) == 0);
                wt[p] = REG_ADDR_W'($urandom_range(0, 15));
            end
            reset = ($urandom_range(0, 199) == 0);
            applyStimulus(($urandom_range(0, 2) != 0),
                          mkEntry(operation_t'($urandom_range(0, 7)), $urandom_range(0, 15), $urandom_range(0, 15),
                                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), rob_ctr),
                          wv, wt, ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 99) == 0));
            rob_ctr++;
            tick();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
